// File: rtl/mul_pipe_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pipe_sched_if
//  Description : Bundle of the requester-side and multiplier-side signals of
//                the shared-multiplier scheduler.
//                slave  : scheduler view (drives grants, issue, responses)
//                master : environment view (requesters + multiplier)
//  Ports       : sched_en, req_valid/req_a/req_b/req_ready (requesters),
//                mul_en_in/mul_a/mul_b/mul_en_out/mul_out (multiplier),
//                rsp_valid/rsp_data (responses), err (desync flag)
//  Revision    : 1.0  initial release
// ============================================================================
interface mul_pipe_sched_if #(
    parameter int N_REQ = 4,
    parameter int SIZE  = 8
);
    logic                    sched_en;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*SIZE-1:0]   req_a;
    logic [N_REQ*SIZE-1:0]   req_b;
    logic [N_REQ-1:0]        req_ready;
    logic                    mul_en_in;
    logic [SIZE-1:0]         mul_a;
    logic [SIZE-1:0]         mul_b;
    logic                    mul_en_out;
    logic [2*SIZE-1:0]       mul_out;
    logic [N_REQ-1:0]        rsp_valid;
    logic [2*SIZE-1:0]       rsp_data;
    logic                    err;

    modport slave (
        input  sched_en, req_valid, req_a, req_b, mul_en_out, mul_out,
        output req_ready, mul_en_in, mul_a, mul_b, rsp_valid, rsp_data, err
    );

    modport master (
        output sched_en, req_valid, req_a, req_b, mul_en_out, mul_out,
        input  req_ready, mul_en_in, mul_a, mul_b, rsp_valid, rsp_data, err
    );
endinterface
`default_nettype wire

// File: rtl/mul_pipe_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pipe_sched
//  Description : Round-robin scheduler sharing one pipelined multiplier among
//                N_REQ requesters. One issue per cycle; a tag pipe matched to
//                the multiplier latency routes each product back to its
//                requester. Per-requester in-flight cap and sticky desync flag.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous reset, active low
//                bus    - mul_pipe_sched_if.slave (requests, grants, issue,
//                         multiplier return, responses, err)
//  Revision    : 1.0  initial release
// ============================================================================
module mul_pipe_sched #(
    parameter int N_REQ   = 4,
    parameter int SIZE    = 8,
    parameter int MUL_LAT = 5,
    parameter int MAX_OUT = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mul_pipe_sched_if.slave   bus
);
    localparam int               C_ID_W    = $clog2(N_REQ);
    localparam logic [2:0]       C_MAX_OUT = 3'(MAX_OUT);
    localparam logic [C_ID_W-1:0] C_LAST_ID = C_ID_W'(N_REQ - 1);

    // ---------------- state ----------------
    logic [C_ID_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [2:0]        out_cnt_q [N_REQ];
    logic [2:0]        out_cnt_d [N_REQ];
    logic              mul_en_in_q, mul_en_in_d;
    logic [SIZE-1:0]   mul_a_q,     mul_a_d;
    logic [SIZE-1:0]   mul_b_q,     mul_b_d;
    logic [C_ID_W-1:0] issue_id_q,  issue_id_d;
    logic              tag_v_q  [MUL_LAT];
    logic              tag_v_d  [MUL_LAT];
    logic [C_ID_W-1:0] tag_id_q [MUL_LAT];
    logic [C_ID_W-1:0] tag_id_d [MUL_LAT];
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [2*SIZE-1:0] rsp_data_q,  rsp_data_d;
    logic              err_q,       err_d;

    // ---------------- combinational ----------------
    logic [N_REQ-1:0]  w_eligible;
    logic [N_REQ-1:0]  w_grant;
    logic              w_accept;
    logic [C_ID_W-1:0] w_win_id;
    logic              w_head_v;
    logic [C_ID_W-1:0] w_head_id;
    logic              w_ret;

    assign w_head_v  = tag_v_q[MUL_LAT-1];
    assign w_head_id = tag_id_q[MUL_LAT-1];
    assign w_ret     = bus.mul_en_out & w_head_v;

    always_comb begin : p_elig
        w_eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_eligible[i] = bus.sched_en & bus.req_valid[i] & (out_cnt_q[i] < C_MAX_OUT);
        end
    end

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin : p_arb
        int idx;
        idx      = 0;
        w_accept = 1'b0;
        w_win_id = '0;
        w_grant  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!w_accept && w_eligible[idx]) begin
                w_accept = 1'b1;
                w_win_id = C_ID_W'(idx);
            end
        end
        if (w_accept) begin
            w_grant[w_win_id] = 1'b1;
        end
    end

    // Grants are held off while reset is asserted so nothing looks accepted.
    assign bus.req_ready = rst_n ? w_grant : '0;

    always_comb begin : p_next
        logic inc;
        logic dec;
        inc         = 1'b0;
        dec         = 1'b0;
        rr_ptr_d    = w_accept ? w_win_id : rr_ptr_q;
        mul_en_in_d = w_accept;
        mul_a_d     = w_accept ? bus.req_a[w_win_id*SIZE +: SIZE] : '0;
        mul_b_d     = w_accept ? bus.req_b[w_win_id*SIZE +: SIZE] : '0;
        issue_id_d  = w_win_id;

        // Stage 0 is loaded from the issue register, so the tag travels one
        // cycle behind mul_en_in and its head lines up with mul_en_out.
        tag_v_d[0]  = mul_en_in_q;
        tag_id_d[0] = issue_id_q;
        for (int s = 1; s < MUL_LAT; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end

        // A retiring head frees its slot whether or not a result came back.
        for (int i = 0; i < N_REQ; i++) begin
            inc = w_accept && (w_win_id == C_ID_W'(i));
            dec = w_head_v && (w_head_id == C_ID_W'(i));
            out_cnt_d[i] = out_cnt_q[i];
            if (inc && !dec) begin
                out_cnt_d[i] = out_cnt_q[i] + 3'd1;
            end else if (dec && !inc) begin
                out_cnt_d[i] = out_cnt_q[i] - 3'd1;
            end
        end

        rsp_valid_d = '0;
        if (w_ret) begin
            rsp_valid_d[w_head_id] = 1'b1;
        end
        rsp_data_d = w_ret ? bus.mul_out : rsp_data_q;
        err_d      = err_q | (bus.mul_en_out ^ w_head_v);
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            rr_ptr_q    <= C_LAST_ID;
            mul_en_in_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            issue_id_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                out_cnt_q[i] <= '0;
            end
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_v_q[s]  <= 1'b0;
                tag_id_q[s] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mul_en_in_q <= mul_en_in_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            issue_id_q  <= issue_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            out_cnt_q   <= out_cnt_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
        end
    end

    assign bus.mul_en_in = mul_en_in_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.err       = err_q;

endmodule
`default_nettype wire
